// File: rtl/bt_pkg.sv
// Balanced-ternary shared definitions.
// Holds the 2-bit trit codes and the trit-to-integer decoder used by the
// calculator top level and the integer-to-trit encoder.
package bt_pkg;

    localparam logic [1:0] BT_NEG  = 2'b01;
    localparam logic [1:0] BT_ZERO = 2'b11;
    localparam logic [1:0] BT_POS  = 2'b10;

    localparam int DATA_W = 8;

    // The unused code 2'b00 falls into the default branch and decodes as 0.
    function automatic logic signed [DATA_W-1:0] bt_trit_to_int(input logic [1:0] i_code);
        case (i_code)
            BT_NEG:  return -8'sd1;
            BT_POS:  return 8'sd1;
            default: return 8'sd0;
        endcase
    endfunction

endpackage

// File: rtl/bt_int_to_trits4.sv
// Signed integer to 4-trit balanced-ternary code, purely combinational.
// Ports:
//   i_value : signed integer, valid range [-40, 40]
//   o_code  : {r3, r2, r1, r0}, two bits per trit, never 2'b00
module bt_int_to_trits4
    import bt_pkg::*;
(
    input  logic signed [DATA_W-1:0] i_value,
    output logic        [7:0]        o_code
);

    localparam logic signed [DATA_W-1:0] K3 = 8'sd3;
    localparam logic signed [DATA_W-1:0] K2 = 8'sd2;
    localparam logic signed [DATA_W-1:0] K1 = 8'sd1;
    localparam logic signed [DATA_W-1:0] K0 = 8'sd0;

    // Repeated division by 3. The remainder is first forced into 0..2 so the
    // subtraction below leaves an exact multiple of 3; a remainder of 2 is
    // re-expressed as -1 with a carry of +1 into the next trit.
    function automatic logic [7:0] enc_trits(input logic signed [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] n;
        logic signed [DATA_W-1:0] m;
        logic signed [DATA_W-1:0] q;
        logic        [7:0]        code;
        n    = v;
        code = {4{BT_ZERO}};
        for (int i = 0; i < 4; i++) begin
            m = n % K3;
            if (m < K0) m = m + K3;
            q = (n - m) / K3;
            if (m == K2) begin
                code[2*i +: 2] = BT_NEG;
                q = q + K1;
            end else if (m == K1) begin
                code[2*i +: 2] = BT_POS;
            end else begin
                code[2*i +: 2] = BT_ZERO;
            end
            n = q;
        end
        return code;
    endfunction

    always_comb begin
        o_code = enc_trits(i_value);
    end

endmodule

// File: rtl/bt_calculator.sv
// Two-trit balanced-ternary calculator with a registered 4-trit result.
// When x1 is -1 the result is X*Y, otherwise X+Y.
// Ports:
//   clk    : rising-edge clock for the result register
//   rst    : asynchronous active-high reset, forces io_out to 8'hFF (R = 0)
//   io_in  : {x1, x0, y1, y0}, two bits per trit
//   io_out : {r3, r2, r1, r0}, registered, one cycle after io_in
module bt_calculator
    import bt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam logic signed [DATA_W-1:0] K3 = 8'sd3;

    logic signed [DATA_W-1:0] w_x1;
    logic signed [DATA_W-1:0] w_x0;
    logic signed [DATA_W-1:0] w_y1;
    logic signed [DATA_W-1:0] w_y0;
    logic signed [DATA_W-1:0] w_x;
    logic signed [DATA_W-1:0] w_y;
    logic signed [DATA_W-1:0] w_sum;
    logic signed [DATA_W-1:0] w_prod;
    logic signed [DATA_W-1:0] w_res;
    logic                     w_mul;
    logic        [7:0]        w_code;
    logic        [7:0]        r_out;

    always_comb begin
        w_x1   = bt_trit_to_int(io_in[7:6]);
        w_x0   = bt_trit_to_int(io_in[5:4]);
        w_y1   = bt_trit_to_int(io_in[3:2]);
        w_y0   = bt_trit_to_int(io_in[1:0]);
        w_x    = K3 * w_x1 + w_x0;
        w_y    = K3 * w_y1 + w_y0;
        w_sum  = w_x + w_y;
        w_prod = w_x * w_y;
        // Only the -1 code selects multiply; an illegal 2'b00 x1 means add.
        w_mul  = (io_in[7:6] == BT_NEG);
        w_res  = w_mul ? w_prod : w_sum;
    end

    bt_int_to_trits4 u_enc (
        .i_value (w_res),
        .o_code  (w_code)
    );

    // Result register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_out <= {4{BT_ZERO}};
        else     r_out <= w_code;
    end

    assign io_out = r_out;

endmodule

// File: tb/tb_bt_calculator.sv
module tb_bt_calculator;

    logic       clk;
    logic       rst;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb[$];

    bt_calculator dut (
        .clk    (clk),
        .rst    (rst),
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    function automatic int dec_trit(input logic [1:0] c);
        if (c == 2'b01) return -1;
        if (c == 2'b10) return 1;
        return 0;
    endfunction

    // Reference: decode, compute, and encode by offsetting to 0..80 and
    // reading plain base-3 digits (digit-1 is the balanced trit).
    function automatic logic [7:0] model(input logic [7:0] v);
        int x, y, r, u, d;
        logic [7:0] code;
        x = 3 * dec_trit(v[7:6]) + dec_trit(v[5:4]);
        y = 3 * dec_trit(v[3:2]) + dec_trit(v[1:0]);
        r = (v[7:6] == 2'b01) ? x * y : x + y;
        u = r + 40;
        code = 8'h00;
        for (int i = 0; i < 4; i++) begin
            d = u % 3;
            u = u / 3;
            code[2*i +: 2] = (d == 0) ? 2'b01 : (d == 1) ? 2'b11 : 2'b10;
        end
        return code;
    endfunction

    task automatic apply(input logic [7:0] v, input logic [7:0] exp, input string tag);
        logic [7:0] prev;
        logic [7:0] want;
        logic       zf;
        @(negedge clk);
        prev  = io_out;
        io_in = v;
        sb.push_back(exp);
        #1;
        chk({tag, "_hold"}, io_out, prev);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        chk(tag, io_out, want);
        zf = (io_out[7:6] == 2'b00) || (io_out[5:4] == 2'b00) ||
             (io_out[3:2] == 2'b00) || (io_out[1:0] == 2'b00);
        chk({tag, "_nz"}, {7'b0, zf}, 8'h00);
    endtask

    initial begin
        logic [1:0] lc [3];
        logic [7:0] v;
        int         k;
        lc[0] = 2'b01;
        lc[1] = 2'b11;
        lc[2] = 2'b10;

        rst   = 1'b1;
        io_in = 8'h3C;
        #1;
        chk("rst_init", io_out, 8'hFF);
        @(negedge clk);
        io_in = 8'h55;
        @(posedge clk);
        #1;
        chk("rst_held", io_out, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release", io_out, 8'hFF);

        apply(8'h55, 8'h96, "mul_55");
        apply(8'h79, 8'hDB, "mul_79");
        apply(8'h75, 8'hEB, "mul_75");
        apply(8'hD5, 8'hDA, "add_D5");
        apply(8'hAA, 8'hED, "add_AA");
        apply(8'h00, 8'hFF, "illegal_00");
        apply(8'h55, 8'h96, "mul_55b");

        // Asynchronous reset mid-cycle, away from any clock edge.
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async", io_out, 8'hFF);
        @(posedge clk);
        #1;
        chk("rst_async_held", io_out, 8'hFF);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 81; n++) begin
            k = n;
            v = 8'h00;
            for (int f = 0; f < 4; f++) begin
                v[2*f +: 2] = lc[k % 3];
                k = k / 3;
            end
            apply(v, model(v), $sformatf("exh_%02h", v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
